// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Shared defaults and helpers for the input_conditioner slice that sits in
// front of the whack_a_mole game core.
//   N_SW_DEFAULT             number of switch channels
//   SAMPLE_DIV_DEFAULT       clock cycles per debounce sample tick
//   STABLE_SAMPLES_DEFAULT   disagreeing ticks needed to commit a new level
//   LONG_PRESS_TICKS_DEFAULT ticks of hold that count as a long press
// -----------------------------------------------------------------------------
package input_cond_pkg;

  localparam int N_SW_DEFAULT             = 16;
  localparam int SAMPLE_DIV_DEFAULT       = 100000;
  localparam int STABLE_SAMPLES_DEFAULT   = 10;
  localparam int LONG_PRESS_TICKS_DEFAULT = 2000;

  typedef logic [N_SW_DEFAULT-1:0] sw_vec_t;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One raw input: two-flop synchroniser, tick-qualified debounce counter,
// committed level register and registered rise/fall pulses.
// Ports:
//   CLK, RST  clock and asynchronous active-high reset
//   TICK      one-cycle sample strobe shared by all channels
//   ARMED     start-up guard; pulses are suppressed while it is low
//   raw       unsynchronised input pin
//   level     debounced level
//   rise      one-cycle pulse on a committed 0->1 change
//   fall      one-cycle pulse on a committed 1->0 change
// -----------------------------------------------------------------------------
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic TICK,
  input  logic ARMED,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // The commit updates level and the pulse on the same edge, so the pulse
  // lines up with the new level appearing on the output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (TICK) begin
        if (sync_q2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync_q2;
          cnt   <= '0;
          rise  <= ARMED & sync_q2;
          fall  <= ARMED & ~sync_q2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Conditions raw SWITCHES and BTNC for the whack_a_mole game core: each pin is
// synchronised and debounced against a shared sample tick, giving clean levels
// and single-cycle change pulses (a switch flip -> one hit, a press -> one
// start).
// Optional feature macro: INPUT_COND_LONG_PRESS_EN adds BTN_LONG, a one-cycle
// pulse once the button has been held for LONG_PRESS_TICKS ticks.
// Ports:
//   CLK           system clock (100 MHz)
//   RST           asynchronous active-high reset
//   SWITCHES_RAW  raw switch pins
//   BTN_RAW       raw centre button
//   SW_LEVEL      debounced switch levels
//   SW_TOGGLE     one-cycle pulse per committed switch change, either way
//   BTN_LEVEL     debounced button level
//   BTN_PRESS     one-cycle pulse on a committed button press
//   BTN_RELEASE   one-cycle pulse on a committed button release
//   BTN_LONG      long-press pulse (only with INPUT_COND_LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_SW             = N_SW_DEFAULT,
  parameter int SAMPLE_DIV       = SAMPLE_DIV_DEFAULT,
  parameter int STABLE_SAMPLES   = STABLE_SAMPLES_DEFAULT,
  parameter int LONG_PRESS_TICKS = LONG_PRESS_TICKS_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_SW-1:0] SWITCHES_RAW,
  input  logic            BTN_RAW,
  output logic [N_SW-1:0] SW_LEVEL,
  output logic [N_SW-1:0] SW_TOGGLE,
  output logic            BTN_LEVEL,
  output logic            BTN_PRESS,
  output logic            BTN_RELEASE
`ifdef INPUT_COND_LONG_PRESS_EN
  ,
  output logic            BTN_LONG
`endif
);

  localparam int            PW        = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(SAMPLE_DIV - 1);
  localparam int            AW        = cnt_width(STABLE_SAMPLES);
  localparam logic [AW-1:0] ARM_LAST  = AW'(STABLE_SAMPLES - 1);

  logic [PW-1:0]   presc;
  logic            tick;
  logic [AW-1:0]   arm_cnt;
  logic            armed;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  // Free-running prescaler; the tick is the last count of each period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc <= '0;
    end else if (presc == PRESC_TOP) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PRESC_TOP);

  // armed only rises after the tick on which the first commits can land, so
  // inputs already active at power-on settle silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (tick && !armed) begin
      if (arm_cnt == ARM_LAST) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + AW'(1);
      end
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_sw (
      .CLK  (CLK),
      .RST  (RST),
      .TICK (tick),
      .ARMED(armed),
      .raw  (SWITCHES_RAW[i]),
      .level(SW_LEVEL[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  assign SW_TOGGLE = sw_rise | sw_fall;

  debounce_channel #(
    .STABLE_SAMPLES(STABLE_SAMPLES)
  ) u_btn (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick),
    .ARMED(armed),
    .raw  (BTN_RAW),
    .level(BTN_LEVEL),
    .rise (BTN_PRESS),
    .fall (BTN_RELEASE)
  );

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam int            HW        = cnt_width(LONG_PRESS_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_TICKS);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_PRESS_TICKS - 1);

  logic [HW-1:0] hold_cnt;

  // Hold counter saturates at the threshold, so the pulse fires at most
  // once per press; it restarts only when the debounced level drops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_cnt <= '0;
      BTN_LONG <= 1'b0;
    end else begin
      BTN_LONG <= 1'b0;
      if (!BTN_LEVEL) begin
        hold_cnt <= '0;
      end else if (tick && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt == HOLD_PRE) begin
          BTN_LONG <= 1'b1;
        end
      end
    end
  end
`else
  // Long-press detection is not built; LONG_PRESS_TICKS has no effect.
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with SAMPLE_DIV=4,
// STABLE_SAMPLES=3, LONG_PRESS_TICKS=5. Every stimulus change that should
// produce a pulse pushes the expected pulse vector and the clock edge it must
// appear on; a monitor pops an entry for every pulse the DUT emits.
// Edge numbering: edge n is the n-th posedge after reset is released. Sample
// ticks are evaluated on edges 4, 8, 12, ...
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int N_SW = 16;

  typedef struct {
    int          edgeNum;
    logic [18:0] pulses;
  } expect_t;

  logic        clk;
  logic        rst;
  logic [15:0] switchesRaw;
  logic        btnRaw;
  logic [15:0] swLevel;
  logic [15:0] swToggle;
  logic        btnLevel;
  logic        btnPress;
  logic        btnRelease;
  logic        btnLong;
  logic [18:0] pulseVec;

  int      edgeNum;
  int      testCount;
  int      failCount;
  int      e;
  expect_t sbQueue[$];
  expect_t expItem;

  input_conditioner #(
    .N_SW            (N_SW),
    .SAMPLE_DIV      (4),
    .STABLE_SAMPLES  (3),
    .LONG_PRESS_TICKS(5)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .SWITCHES_RAW(switchesRaw),
    .BTN_RAW     (btnRaw),
    .SW_LEVEL    (swLevel),
    .SW_TOGGLE   (swToggle),
    .BTN_LEVEL   (btnLevel),
    .BTN_PRESS   (btnPress),
    .BTN_RELEASE (btnRelease)
`ifdef INPUT_COND_LONG_PRESS_EN
    ,
    .BTN_LONG    (btnLong)
`endif
  );

`ifndef INPUT_COND_LONG_PRESS_EN
  assign btnLong = 1'b0;
`endif

  // Bit 18 long, 17 release, 16 press, 15:0 switch toggles.
  assign pulseVec = {btnLong, btnRelease, btnPress, swToggle};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter restarted by reset, independent of the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) edgeNum <= 0;
    else     edgeNum <= edgeNum + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", tag,
               observed, expected, edgeNum);
    end
  endtask

  // First tick edge able to see a change driven before edge p is p+2 rounded
  // up to a multiple of 4; the commit is two ticks later.
  function automatic int commitEdge(input int p);
    int firstTick;
    firstTick = ((p + 2 + 3) / 4) * 4;
    return firstTick + 8;
  endfunction

  // Called just after a negedge, so the next posedge is edgeNum+1.
  task automatic applyStimulus(input logic [15:0] sw, input logic btn,
                               input logic [18:0] expPulse, output int commitAt);
    expect_t item;
    switchesRaw = sw;
    btnRaw      = btn;
    commitAt    = commitEdge(edgeNum + 1);
    if (expPulse != '0) begin
      item.edgeNum = commitAt;
      item.pulses  = expPulse;
      sbQueue.push_back(item);
    end
  endtask

  task automatic waitEdge(input int target);
    int guard;
    guard = 0;
    while (edgeNum < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (edgeNum < target) checkOutput("wait_bound", edgeNum, target);
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && pulseVec != '0) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_pulse", {13'd0, pulseVec}, 32'd0);
      end else begin
        expItem = sbQueue.pop_front();
        checkOutput("pulse_edge", edgeNum, expItem.edgeNum);
        checkOutput("pulse_value", {13'd0, pulseVec}, {13'd0, expItem.pulses});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testCount   = 0;
    failCount   = 0;
    rst         = 1'b1;
    switchesRaw = 16'h0005;
    btnRaw      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sw_level", {16'd0, swLevel}, 32'd0);
    checkOutput("reset_btn_level", {31'd0, btnLevel}, 32'd0);
    checkOutput("reset_pulses", {13'd0, pulseVec}, 32'd0);
    rst = 1'b0;

    // Power-on switches commit on the third tick without a toggle.
    waitEdge(11);
    checkOutput("s1_level_before", {16'd0, swLevel}, 32'h0000);
    waitEdge(12);
    checkOutput("s1_level_after", {16'd0, swLevel}, 32'h0005);

    // Single switch flip once armed.
    waitEdge(14);
    applyStimulus(16'h0085, 1'b0, 19'h00080, e);
    waitEdge(e - 1);
    checkOutput("s2_level_before", {16'd0, swLevel}, 32'h0005);
    waitEdge(e);
    checkOutput("s2_level_after", {16'd0, swLevel}, 32'h0085);

    // Button bounces 1,0,1 one tick each, then holds.
    waitEdge(e + 2);
    applyStimulus(16'h0085, 1'b1, 19'h0, e);
    repeat (4) @(negedge clk);
    applyStimulus(16'h0085, 1'b0, 19'h0, e);
    repeat (4) @(negedge clk);
    applyStimulus(16'h0085, 1'b1, 19'h10000, e);
    waitEdge(e - 1);
    checkOutput("s3_btn_before", {31'd0, btnLevel}, 32'd0);
    waitEdge(e);
    checkOutput("s3_btn_after", {31'd0, btnLevel}, 32'd1);

    // Switches 0 and 15 flip together.
    waitEdge(e + 2);
    applyStimulus(16'h8084, 1'b1, 19'h08001, e);
    waitEdge(e);
    checkOutput("s4_level", {16'd0, swLevel}, 32'h8084);

    // Reset while bit 3 is two ticks into its count.
    waitEdge(e + 2);
    applyStimulus(16'h808C, 1'b1, 19'h0, e);
    waitEdge(e - 4);
    checkOutput("s5_queue_idle", sbQueue.size(), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("s5_rst_sw_level", {16'd0, swLevel}, 32'd0);
    checkOutput("s5_rst_btn_level", {31'd0, btnLevel}, 32'd0);
    checkOutput("s5_rst_pulses", {13'd0, pulseVec}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitEdge(11);
    checkOutput("s5_level_before", {16'd0, swLevel}, 32'h0000);
    waitEdge(12);
    checkOutput("s5_level_after", {16'd0, swLevel}, 32'h808C);
    checkOutput("s5_btn_after", {31'd0, btnLevel}, 32'd1);

    // Two-tick glitch on bit 1 must be ignored.
    waitEdge(14);
    applyStimulus(16'h808E, 1'b1, 19'h0, e);
    repeat (8) @(negedge clk);
    applyStimulus(16'h808C, 1'b1, 19'h0, e);
    repeat (16) @(negedge clk);
    checkOutput("glitch_level", {16'd0, swLevel}, 32'h808C);

    // Release the button committed during the guard window.
    applyStimulus(16'h808C, 1'b0, 19'h20000, e);
    waitEdge(e);
    checkOutput("release_btn", {31'd0, btnLevel}, 32'd0);

    // Press, hold eight ticks, release.
    waitEdge(e + 2);
    applyStimulus(16'h808C, 1'b1, 19'h10000, e);
`ifdef INPUT_COND_LONG_PRESS_EN
    expItem.edgeNum = e + 20;
    expItem.pulses  = 19'h40000;
    sbQueue.push_back(expItem);
`endif
    waitEdge(e + 32);
    checkOutput("s6_btn_held", {31'd0, btnLevel}, 32'd1);
    applyStimulus(16'h808C, 1'b0, 19'h20000, e);
    waitEdge(e + 4);
    checkOutput("s6_btn_released", {31'd0, btnLevel}, 32'd0);
    checkOutput("queue_drained", sbQueue.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
